alu_cmd_ctrl: RTL and testbench
===============================

Name: alu_cmd_ctrl

Overview:
Byte-stream command sequencer that acts as the initiator for the 16-bit ALU. It assembles a 6-byte command frame from the receive byte stream and drives A, B and ALU_FUN. It then waits for the unit flag, selects the matching result bus and returns a 3-byte response over a valid/ready transmit handshake. It sits between the serial-receive synchroniser and the ALU inside the system-control domain.

Parameters:
SYNC_BYTE, 8'hCC, frame start marker.
TIMEOUT, 8, maximum cycles to wait for a unit flag after issue (1..255).
ERR_BYTE, 8'hEE, status byte returned on timeout.

Ports:
clk  in  1  system clock, all logic rising-edge.
RST  in  1  asynchronous active-low reset.
rx_data  in  8  received byte.
rx_valid  in  1  single-cycle strobe, rx_data valid; always accepted (no backpressure).
alu_a  out  16  operand A to ALU.
alu_b  out  16  operand B to ALU.
alu_fun  out  4  ALU function code.
arith_out, logic_out, cmp_out, shift_out  in  16 each  ALU result buses.
carry_in  in  1  ALU carry.
arith_flag, logic_flag, cmp_flag, shift_flag  in  1 each  ALU unit-valid flags.
tx_data  out  8  response byte.
tx_valid  out  1  response byte valid.
tx_ready  in  1  consumer ready; transfer occurs when tx_valid && tx_ready.
busy  out  1  high from first payload byte until last response byte is transferred.

Behaviour:
- Reset (RST=0, async): state IDLE; alu_a=0, alu_b=0, alu_fun=0, tx_data=0, tx_valid=0, busy=0; byte counter and timeout counter cleared.
- Frame: SYNC_BYTE, A[7:0], A[15:8], B[7:0], B[15:8], FUN (low nibble used, high nibble ignored).
- IDLE: rx_valid with rx_data==SYNC_BYTE -> RX_PAYLOAD (cnt=0). Any other byte is dropped.
- RX_PAYLOAD: each rx_valid stores one byte into a shadow register and increments cnt. The 5th byte -> ISSUE. SYNC_BYTE inside the payload is data, not a restart. busy=1.
- ISSUE (1 cycle): alu_a/alu_b/alu_fun load from shadows together. Outputs are held stable until the next ISSUE. Next state WAIT; timeout counter=0.
- WAIT: the expected unit is decoded from alu_fun[3:2]: 00 arith, 01 logic, 10 cmp, 11 shift.
  - Only the expected flag counts. Flags from other units are ignored.
  - When the expected flag is 1: latch the matching result and status = {carry_in (arith only, else 0), 5'b0, alu_fun[3:2]}, then go to SEND.
  - The ALU is registered, so the flag nominally arrives 2 cycles after ISSUE (one cycle for the bus update, one for the register).
  - If the counter reaches TIMEOUT with no flag: result=16'h0000, status=ERR_BYTE, go to SEND.
- SEND: bytes go out in the order result[7:0], result[15:8], status.
  - tx_valid=1 with tx_data stable until the handshake completes.
  - The next byte is presented in the cycle after each transfer, so tx_valid may stay high back-to-back.
  - After the 3rd transfer: tx_valid=0, busy=0, state IDLE.
- rx_valid during ISSUE/WAIT/SEND: byte dropped, no effect. The sender must wait for busy=0.
- Reset mid-operation: immediate return to reset values. A partial frame and any pending response are discarded.
- Worst-case latency from last FUN byte to first tx_valid: 1 (ISSUE) + up to TIMEOUT + 1 cycles.

Decomposition:
- Shared package alu_ctrl_pkg: state encoding (IDLE, RX_PAYLOAD, ISSUE, WAIT, SEND), unit-select constants (ARITH=2'b00, LOGIC=2'b01, CMP=2'b10, SHIFT=2'b11), FRAME_LEN=6, RESP_LEN=3.
- One natural sub-module, alu_resp_serializer: 24-bit load, 3-byte valid/ready shifter, done pulse. The FSM, frame assembly and result mux stay in the top module.

Test Plan:
- Add, full frame CC,05,00,03,00,00 with tx_ready=1: alu_a=0005, alu_b=0003, alu_fun=0. Response 08,00,00. busy falls after the 3rd transfer.
- Arith carry: A=FFFF, B=0001, FUN=0: response 00,00,80 (carry bit set, unit 00).
- Backpressure, CMP equal: A=1234, B=1234, FUN=9. Hold tx_ready=0 for 5 cycles: tx_valid and tx_data (low byte) stay constant. Then the response is exactly the 3 bytes of the CMP result, status 02.
- Timeout: tie all flags low. Send a shift frame FUN=C: after TIMEOUT cycles in WAIT the response is 00,00,EE.
- Framing: send 55,AA,CC, then 5 payload bytes including a CC at byte 2. The first two bytes are ignored, the CC is taken as A[15:8], and exactly one response is produced. Bytes sent while busy=1 produce no extra response.
- Async reset asserted in WAIT and in SEND mid-response: all outputs return to 0 without a clock edge. A new frame after release completes normally.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU command sequencer.
package alu_ctrl_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FUN_W     = 4;
  localparam int unsigned FRAME_LEN = 6;
  localparam int unsigned RESP_LEN  = 3;

  localparam logic [1:0] ARITH = 2'b00;
  localparam logic [1:0] LOGIC = 2'b01;
  localparam logic [1:0] CMP   = 2'b10;
  localparam logic [1:0] SHIFT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    RX_PAYLOAD,
    ISSUE,
    WAIT,
    SEND
  } state_e;

  // Assembled command: payload bytes land LSB-first, FUN nibble on top.
  typedef struct packed {
    logic [FUN_W-1:0]  fun;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] a;
  } alu_cmd_t;

  // Response word: result low byte is sent first, status last.
  typedef struct packed {
    logic [BYTE_W-1:0] status;
    logic [DATA_W-1:0] result;
  } alu_resp_t;

endpackage

// File: rtl/alu_resp_serializer.sv
// Three-byte valid/ready response shifter; done_c flags the final transfer.
module alu_resp_serializer
  import alu_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  alu_resp_t         resp,
  input  logic              tx_ready,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  output logic              done_c
);

  logic [DATA_W-1:0] sh_q;
  logic [1:0]        rem_q;
  logic              xfer;

  assign xfer   = tx_valid && tx_ready;
  assign done_c = xfer && (rem_q == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
      sh_q     <= '0;
      rem_q    <= '0;
    end else if (load) begin
      tx_data  <= resp.result[7:0];
      sh_q     <= {resp.status, resp.result[15:8]};
      rem_q    <= 2'(RESP_LEN - 1);
      tx_valid <= 1'b1;
    end else if (xfer) begin
      if (rem_q == 2'd0) begin
        tx_valid <= 1'b0;
      end else begin
        tx_data <= sh_q[7:0];
        sh_q    <= {8'h00, sh_q[15:8]};
        rem_q   <= rem_q - 2'd1;
      end
    end
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Byte-stream command sequencer: assembles a 6-byte frame, drives the ALU,
// waits for the selected unit flag and returns a 3-byte response.
module alu_cmd_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = 8'hCC,
  parameter int unsigned TIMEOUT   = 8,
  parameter logic [7:0]  ERR_BYTE  = 8'hEE
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FUN_W-1:0]  alu_fun,
  input  logic [DATA_W-1:0] arith_out,
  input  logic [DATA_W-1:0] logic_out,
  input  logic [DATA_W-1:0] cmp_out,
  input  logic [DATA_W-1:0] shift_out,
  input  logic              carry_in,
  input  logic              arith_flag,
  input  logic              logic_flag,
  input  logic              cmp_flag,
  input  logic              shift_flag,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 2);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [2:0]       cnt_q;
  logic [7:0]       tmo_q;
  logic [31:0]      ab_sh_q;
  logic [FUN_W-1:0] fun_sh_q;
  alu_cmd_t         cmd;

  logic              exp_flag;
  logic [DATA_W-1:0] unit_res;
  logic              unit_cy;
  logic              load_c;
  alu_resp_t         resp_d;
  logic              ser_done_c;

  assign cmd = alu_cmd_t'({fun_sh_q, ab_sh_q});

  // Only the unit addressed by the issued function code is observed.
  always_comb begin
    exp_flag = 1'b0;
    unit_res = '0;
    unit_cy  = 1'b0;
    unique case (alu_fun[3:2])
      ARITH: begin exp_flag = arith_flag; unit_res = arith_out; unit_cy = carry_in; end
      LOGIC: begin exp_flag = logic_flag; unit_res = logic_out; end
      CMP:   begin exp_flag = cmp_flag;   unit_res = cmp_out;   end
      SHIFT: begin exp_flag = shift_flag; unit_res = shift_out; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    resp_d  = '0;
    case (state_q)
      IDLE:       if (rx_valid && rx_data == SYNC_BYTE) state_d = RX_PAYLOAD;
      RX_PAYLOAD: if (rx_valid && cnt_q == LAST_IDX) state_d = ISSUE;
      ISSUE:      state_d = WAIT;
      WAIT: begin
        if (exp_flag) begin
          state_d       = SEND;
          load_c        = 1'b1;
          resp_d.result = unit_res;
          resp_d.status = {unit_cy, 5'b0, alu_fun[3:2]};
        end else if (tmo_q == TMO_LAST) begin
          state_d       = SEND;
          load_c        = 1'b1;
          resp_d.status = ERR_BYTE;
        end
      end
      SEND:       if (ser_done_c) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tmo_q    <= '0;
      ab_sh_q  <= '0;
      fun_sh_q <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_fun  <= '0;
      busy     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: cnt_q <= '0;
        RX_PAYLOAD: begin
          if (rx_valid) begin
            busy  <= 1'b1;
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == LAST_IDX) fun_sh_q <= rx_data[3:0];
            else                   ab_sh_q  <= {rx_data, ab_sh_q[31:8]};
          end
        end
        ISSUE: begin
          alu_a   <= cmd.a;
          alu_b   <= cmd.b;
          alu_fun <= cmd.fun;
          tmo_q   <= '0;
        end
        WAIT: if (!exp_flag) tmo_q <= tmo_q + 8'd1;
        SEND: if (ser_done_c) busy <= 1'b0;
        default: ;
      endcase
    end
  end

  alu_resp_serializer u_ser (
    .clk      (clk),
    .rst_n    (RST),
    .load     (load_c),
    .resp     (resp_d),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .done_c   (ser_done_c)
  );

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a small registered ALU model.
module tb_alu_cmd_ctrl;

  logic        clk;
  logic        RST;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_fun;
  logic [15:0] arith_out, logic_out, cmp_out, shift_out;
  logic        carry_in;
  logic        arith_flag, logic_flag, cmp_flag, shift_flag;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  alu_cmd_ctrl dut (
    .clk(clk), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
    .carry_in(carry_in),
    .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU model: two register stages; every unit reports when its result
  // matches the operands currently driven, non-arith carry is garbage 1.
  logic [35:0] s1_q, tag_q;
  logic [15:0] ar_q, lo_q, cm_q, sh_q;
  logic        cy_q;
  logic        flag_en;
  logic        hit;

  always @(posedge clk) begin
    s1_q           <= {alu_fun, alu_b, alu_a};
    tag_q          <= s1_q;
    {cy_q, ar_q}   <= {1'b0, s1_q[15:0]} + {1'b0, s1_q[31:16]};
    lo_q           <= s1_q[15:0] & s1_q[31:16];
    cm_q           <= (s1_q[15:0] == s1_q[31:16]) ? 16'h0001 : 16'h0000;
    sh_q           <= {s1_q[14:0], 1'b0};
  end

  assign hit        = flag_en && (tag_q == {alu_fun, alu_b, alu_a});
  assign arith_flag = hit;
  assign logic_flag = hit;
  assign cmp_flag   = hit;
  assign shift_flag = hit;
  assign arith_out  = ar_q;
  assign logic_out  = lo_q;
  assign cmp_out    = cm_q;
  assign shift_out  = sh_q;
  assign carry_in   = (tag_q[35:34] == 2'b00) ? cy_q : 1'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
  endtask

  task automatic rx_idle();
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input logic [15:0] a, input logic [15:0] b, input logic [7:0] f);
    send_byte(8'hCC);
    send_byte(a[7:0]);
    send_byte(a[15:8]);
    send_byte(b[7:0]);
    send_byte(b[15:8]);
    send_byte(f);
    rx_idle();
  endtask

  task automatic wait_tx_valid(output int cyc);
    cyc = 0;
    while (!tx_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Collects up to three bytes with tx_ready held high; r[7:0] is the first.
  task automatic get_resp(output logic [23:0] r, output int nb);
    r  = '0;
    nb = 0;
    tx_ready = 1'b1;
    for (int c = 0; c < 60 && nb < 3; c++) begin
      if (tx_valid) begin
        r[nb*8 +: 8] = tx_data;
        nb++;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_alu_a"},    32'(alu_a),    32'h0);
    check({tag, "_alu_b"},    32'(alu_b),    32'h0);
    check({tag, "_alu_fun"},  32'(alu_fun),  32'h0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'h0);
    check({tag, "_tx_data"},  32'(tx_data),  32'h0);
    check({tag, "_busy"},     32'(busy),     32'h0);
  endtask

  logic [23:0] r;
  int          nb;
  int          cyc;
  int          n_extra;
  logic [7:0]  first;
  logic        stable;

  initial begin
    RST = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1; flag_en = 1'b1;
    #12;
    check_zero("reset");
    @(negedge clk);
    RST = 1'b1;

    // Add 5 + 3
    send_frame(16'h0005, 16'h0003, 8'h00);
    check("add_busy", 32'(busy), 32'h1);
    get_resp(r, nb);
    check("add_resp",    32'(r),        32'h000008);
    check("add_nbytes",  32'(nb),       32'd3);
    check("add_busy_lo", 32'(busy),     32'h0);
    check("add_txv_lo",  32'(tx_valid), 32'h0);
    check("add_alu_a",   32'(alu_a),    32'h0005);
    check("add_alu_b",   32'(alu_b),    32'h0003);
    check("add_alu_fun", 32'(alu_fun),  32'h0);

    // Arith carry
    send_frame(16'hFFFF, 16'h0001, 8'h00);
    get_resp(r, nb);
    check("carry_resp", 32'(r), 32'h800000);

    // Compare equal with backpressure on the first byte
    tx_ready = 1'b0;
    send_frame(16'h1234, 16'h1234, 8'h09);
    wait_tx_valid(cyc);
    check("bp_valid", 32'(tx_valid), 32'h1);
    first  = tx_data;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!tx_valid || tx_data !== first) stable = 1'b0;
    end
    check("bp_hold",  32'(stable), 32'h1);
    check("bp_byte0", 32'(first),  32'h01);
    get_resp(r, nb);
    check("bp_resp",   32'(r),  32'h020001);
    check("bp_nbytes", 32'(nb), 32'd3);

    // Timeout on a shift command with every flag low
    flag_en = 1'b0;
    send_frame(16'h00AB, 16'h0003, 8'h0C);
    wait_tx_valid(cyc);
    check("tmo_latency", 32'(cyc), 32'd9);
    get_resp(r, nb);
    check("tmo_resp",    32'(r),       32'hEE0000);
    check("tmo_alu_fun", 32'(alu_fun), 32'hC);
    flag_en = 1'b1;

    // Framing: junk before sync, SYNC value inside payload, traffic while busy
    send_byte(8'h55);
    send_byte(8'hAA);
    send_frame(16'hCC11, 16'h00FF, 8'h54);
    fork
      get_resp(r, nb);
      begin
        send_byte(8'hCC);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        rx_idle();
      end
    join
    check("frm_resp",    32'(r),       32'h010011);
    check("frm_alu_a",   32'(alu_a),   32'hCC11);
    check("frm_alu_fun", 32'(alu_fun), 32'h4);
    n_extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_valid) n_extra++;
    end
    check("frm_no_extra", 32'(n_extra), 32'd0);
    check("frm_busy",     32'(busy),    32'h0);

    // Async reset while waiting for the unit flag
    send_frame(16'h0102, 16'h0304, 8'h00);
    @(negedge clk);
    #2 RST = 1'b0;
    #1 check_zero("rst_wait");
    @(negedge clk);
    RST = 1'b1;

    // Async reset partway through the response
    send_frame(16'h0506, 16'h0708, 8'h00);
    wait_tx_valid(cyc);
    check("rs_byte0", 32'(tx_data), 32'h0E);
    @(negedge clk);
    tx_ready = 1'b0;
    check("rs_byte1",  32'(tx_data),  32'h0C);
    check("rs_valid1", 32'(tx_valid), 32'h1);
    #2 RST = 1'b0;
    #1 check_zero("rst_send");
    @(negedge clk);
    RST = 1'b1;
    tx_ready = 1'b1;

    // Clean frame after reset
    send_frame(16'h0010, 16'h0020, 8'h00);
    get_resp(r, nb);
    check("post_resp",   32'(r),    32'h000030);
    check("post_nbytes", 32'(nb),   32'd3);
    check("post_busy",   32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
